// File: rtl/mem_stage_pkg.sv
// Purpose: shared types and defaults for the MEM-stage access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

   // Controller states: wait for an access, talk to memory, report completion
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Byte address of data-memory word 0
   localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

   // Word-address width of the memory port
   localparam int unsigned ADDR_W_DEF = 16;

endpackage

// File: rtl/mem_addr_map.sv
// Purpose: maps an ALU byte address onto the word-addressed memory port and flags out-of-range accesses.
// Latency: purely combinational.
// Backpressure: none.
module mem_addr_map
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
   input  logic [31:0]       byte_addr_i,
   output logic [ADDR_W-1:0] word_addr_o,
   output logic              range_err_o
);

   logic [31:0] off;
   logic [1:0]  unused_lsb;

   // Rebase onto word 0, drop the byte lane, and flag anything below the base or past capacity
   always_comb begin
      off         = byte_addr_i - BASE_ADDR;
      word_addr_o = off[ADDR_W+1:2];
      unused_lsb  = off[1:0];
      range_err_o = (byte_addr_i < BASE_ADDR) | (|off[31:ADDR_W+2]);
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage controller; runs one req/ready memory access per load/store and freezes the pipeline meanwhile.
// Latency: 3 cycles minimum per access (IDLE, BUSY with ready, DONE); non-memory instructions pass with no stall.
// Backpressure: mem_ready may be held low indefinitely; freeze stays high for the whole of BUSY.
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN_MEM,
   input  logic              MEM_W_EN_MEM,
   input  logic [31:0]       ALU_RES_MEM,
   input  logic [31:0]       VAL_RM_MEM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   output logic              freeze,
   output logic [31:0]       MEM_RDATA,
   output logic              ADDR_ERR
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                acc;
   logic                freeze_c;
   logic                req_c;
   logic [ADDR_W-1:0]   word_addr;
   logic                range_err;

   assign acc = MEM_R_EN_MEM | MEM_W_EN_MEM;

   mem_addr_map #(
      .BASE_ADDR (BASE_ADDR),
      .ADDR_W    (ADDR_W)
   ) u_addr_map (
      .byte_addr_i (ALU_RES_MEM),
      .word_addr_o (word_addr),
      .range_err_o (range_err)
   );

   // Next-state and output decode; a simultaneous read+write enable is issued as a write
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      freeze_c = 1'b0;
      req_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            freeze_c = acc;
            if (acc) begin
               if (range_err) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  addr_d  = word_addr;
                  we_d    = MEM_W_EN_MEM;
                  wdata_d = VAL_RM_MEM;
               end
            end
         end
         ST_BUSY: begin
            req_c    = 1'b1;
            freeze_c = 1'b1;
            if (mem_ready) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
            end
         end
         ST_DONE: begin
            // MEM-stage inputs still show the finished access here, so they are not looked at
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and access registers; reset kills any in-flight request without reporting completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // freeze is combinational from acc in IDLE, so it is gated off directly while reset is held
   always_comb begin
      freeze    = freeze_c & rst;
      mem_req   = req_c;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      MEM_RDATA = rdata_q;
      ADDR_ERR  = err_q;
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

   typedef struct {
      logic        r_en;
      logic        w_en;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
      logic        rdy_idle;
      logic        exp_err;
      logic [15:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_mrdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] mrdata;
      int          req_cyc;
      int          frz_cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        MEM_R_EN_MEM;
   logic        MEM_W_EN_MEM;
   logic [31:0] ALU_RES_MEM;
   logic [31:0] VAL_RM_MEM;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        freeze;
   logic [31:0] MEM_RDATA;
   logic        ADDR_ERR;

   int   n_assert;
   int   n_fail;
   vec_t vecs[9];
   exp_t sb[$];

   mem_stage_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .MEM_R_EN_MEM (MEM_R_EN_MEM),
      .MEM_W_EN_MEM (MEM_W_EN_MEM),
      .ALU_RES_MEM  (ALU_RES_MEM),
      .VAL_RM_MEM   (VAL_RM_MEM),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .freeze       (freeze),
      .MEM_RDATA    (MEM_RDATA),
      .ADDR_ERR     (ADDR_ERR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One complete access: IDLE -> [BUSY...] -> DONE, then step into the next IDLE
   task automatic do_access(input int i);
      vec_t v;
      exp_t e;
      exp_t got;
      int   req_cyc;
      int   frz_cyc;
      v       = vecs[i];
      req_cyc = 0;
      frz_cyc = 0;
      MEM_R_EN_MEM = v.r_en;
      MEM_W_EN_MEM = v.w_en;
      ALU_RES_MEM  = v.addr;
      VAL_RM_MEM   = v.wdata;
      mem_ready    = v.rdy_idle;
      mem_rdata    = 32'hCAFE0000 + 32'(i);
      e.err     = v.exp_err;
      e.mrdata  = v.exp_mrdata;
      e.req_cyc = v.exp_err ? 0 : v.delay + 1;
      e.frz_cyc = v.exp_err ? 1 : v.delay + 2;
      sb.push_back(e);
      // IDLE cycle
      @(negedge clk);
      if (mem_req) req_cyc++;
      if (freeze) frz_cyc++;
      chk("idle_freeze", 32'(freeze), 32'd1);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_addr_err", 32'(ADDR_ERR), 32'd0);
      @(posedge clk); #1;
      if (!v.exp_err) begin
         for (int k = 0; k <= v.delay; k++) begin
            mem_ready = (k == v.delay);
            mem_rdata = (k == v.delay) ? v.rdata : 32'h5A5A0000 + 32'(k);
            @(negedge clk);
            if (mem_req) req_cyc++;
            if (freeze) frz_cyc++;
            chk("busy_addr", 32'(mem_addr), 32'(v.exp_addr));
            chk("busy_we", 32'(mem_we), 32'(v.exp_we));
            if (v.exp_we) chk("busy_wdata", mem_wdata, v.wdata);
            @(posedge clk); #1;
         end
         mem_ready = 1'b0;
         mem_rdata = 32'hBAD0BAD0;
      end
      // DONE cycle: inputs still hold the finished access
      @(negedge clk);
      if (mem_req) req_cyc++;
      if (freeze) frz_cyc++;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL sb_underflow: no expected entry for access %0d", i);
      end else begin
         got = sb.pop_front();
         chk("done_addr_err", 32'(ADDR_ERR), 32'(got.err));
         chk("done_mem_rdata", MEM_RDATA, got.mrdata);
         chk("req_cycles", 32'(req_cyc), 32'(got.req_cyc));
         chk("freeze_cycles", 32'(frz_cyc), 32'(got.frz_cyc));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      //         r  w  addr        wdata         dly rdata         rdyI err addr     we  MEM_RDATA after
      vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 16'd1, 1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 4, 32'h0, 1'b0, 1'b0, 16'd2, 1'b1, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b0, 32'd1000, 32'h0, 0, 32'h0, 1'b0, 1'b1, 16'd0, 1'b0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 1'b0, 16'd0, 1'b1, 32'hDEADBEEF};
      vecs[4] = '{1'b1, 1'b0, 32'd263164, 32'h0, 2, 32'h0BADF00D, 1'b0, 1'b0, 16'hFFFF, 1'b0, 32'h0BADF00D};
      vecs[5] = '{1'b1, 1'b0, 32'd263168, 32'h0, 0, 32'h0, 1'b0, 1'b1, 16'd0, 1'b0, 32'h0BADF00D};
      vecs[6] = '{1'b1, 1'b0, 32'd1031, 32'h0, 0, 32'h11112222, 1'b1, 1'b0, 16'd1, 1'b0, 32'h11112222};
      vecs[7] = '{1'b1, 1'b0, 32'd1036, 32'h0, 1, 32'h33334444, 1'b1, 1'b0, 16'd3, 1'b0, 32'h33334444};
      vecs[8] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h77777777, 0, 32'h0, 1'b0, 1'b1, 16'd0, 1'b1, 32'h33334444};

      // Reset values, with a load presented so freeze gating is exercised
      rst          = 1'b0;
      MEM_R_EN_MEM = 1'b1;
      MEM_W_EN_MEM = 1'b0;
      ALU_RES_MEM  = 32'd1028;
      VAL_RM_MEM   = 32'hFFFFFFFF;
      mem_ready    = 1'b1;
      mem_rdata    = 32'h0;
      #12;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_mem_rdata", MEM_RDATA, 32'd0);
      chk("rst_addr_err", 32'(ADDR_ERR), 32'd0);
      chk("rst_freeze", 32'(freeze), 32'd0);
      MEM_R_EN_MEM = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      // Non-memory instructions with ready held high: no stall, no request
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("nop_freeze", 32'(freeze), 32'd0);
         chk("nop_req", 32'(mem_req), 32'd0);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;

      // Table of accesses, back to back (6 and 7 are consecutive loads)
      for (int i = 0; i < 9; i++) do_access(i);

      // Reset mid-BUSY: request and freeze must drop without waiting for a clock edge
      MEM_R_EN_MEM = 1'b1;
      MEM_W_EN_MEM = 1'b0;
      ALU_RES_MEM  = 32'd1040;
      mem_ready    = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_busy_req", 32'(mem_req), 32'd1);
      @(posedge clk); #2;
      rst       = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("async_rst_req", 32'(mem_req), 32'd0);
      chk("async_rst_freeze", 32'(freeze), 32'd0);
      @(posedge clk); #1;
      MEM_R_EN_MEM = 1'b0;
      rst          = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_req", 32'(mem_req), 32'd0);
         chk("post_rst_freeze", 32'(freeze), 32'd0);
         chk("post_rst_addr_err", 32'(ADDR_ERR), 32'd0);
         chk("post_rst_mem_rdata", MEM_RDATA, 32'd0);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;

      // Controller still works after a mid-access reset
      do_access(0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
